// File: rtl/vga_frame_scheduler_if.sv
// Bundle of the signals between the frame scheduler and its neighbours.
//
// The scheduler sits between three parties: the VGA timing generator, the
// camera capture writer and the dual-bank frame-buffer BRAM.
//
// Modports:
//   slave  - the scheduler side (vga_frame_scheduler)
//   master - the environment side (timing generator, writer, BRAM, DAC)
//
// Signals:
//   i_x_counter/i_y_counter   pixel column 0..799 / line 0..524
//   i_video, i_hsync, i_vsync active-area flag and active-low syncs
//   i_wr_frame_done           one-cycle pulse, writer finished o_wr_bank
//   i_rd_data                 RGB444 read data from BRAM
//   o_wr_bank, o_wr_ready     bank the writer fills, and permission to start
//   o_rd_bank, o_rd_en,
//   o_rd_addr                 BRAM read port (bank select, enable, address)
//   o_red/o_green/o_blue      pixel to DAC
//   o_hsync, o_vsync          syncs delayed to line up with RGB
//   o_drop_count              ignored frame-done pulses (FB_DROP_COUNT_EN only)
interface vga_frame_scheduler_if #(
    parameter int unsigned ADDR_W = 17
);
    logic [9:0]        i_x_counter;
    logic [9:0]        i_y_counter;
    logic              i_video;
    logic              i_hsync;
    logic              i_vsync;
    logic              i_wr_frame_done;
    logic [11:0]       i_rd_data;
    logic              o_wr_bank;
    logic              o_wr_ready;
    logic              o_rd_bank;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [3:0]        o_red;
    logic [3:0]        o_green;
    logic [3:0]        o_blue;
    logic              o_hsync;
    logic              o_vsync;
`ifdef FB_DROP_COUNT_EN
    logic [15:0]       o_drop_count;
`endif

    modport slave (
        input  i_x_counter, i_y_counter, i_video, i_hsync, i_vsync, i_wr_frame_done,
        input  i_rd_data,
        output o_wr_bank, o_wr_ready, o_rd_bank, o_rd_en, o_rd_addr,
        output o_red, o_green, o_blue, o_hsync, o_vsync
`ifdef FB_DROP_COUNT_EN
        , output o_drop_count
`endif
    );

    modport master (
        output i_x_counter, i_y_counter, i_video, i_hsync, i_vsync, i_wr_frame_done,
        output i_rd_data,
        input  o_wr_bank, o_wr_ready, o_rd_bank, o_rd_en, o_rd_addr,
        input  o_red, o_green, o_blue, o_hsync, o_vsync
`ifdef FB_DROP_COUNT_EN
        , input o_drop_count
`endif
    );
endinterface

// File: rtl/vga_frame_scheduler.sv
// Two-bank frame-buffer scheduler between the OV7670 capture writer and a
// 640x480@60 VGA timing generator.
//
// - Swaps display and write banks only at line V_DISP (start of vertical
//   blanking), so a displayed frame never tears.
// - Builds 2x-upscaled read addresses from the VGA counters without a
//   multiplier (running row_base register).
// - Delays video/hsync/vsync by PIPE = RD_LAT + 2 cycles so they line up with
//   the registered RGB output.
//
// Ports:
//   i_clk   pixel clock (25 MHz)
//   i_rstn  asynchronous active-low reset
//   bus     vga_frame_scheduler_if.slave (counters, syncs, writer handshake,
//           BRAM read port, RGB/sync outputs)
//
// Optional macro FB_DROP_COUNT_EN: adds bus.o_drop_count, a saturating count of
// frame-done pulses ignored because a swap was already pending.
module vga_frame_scheduler #(
    parameter int unsigned IMG_W  = 320,
    parameter int unsigned IMG_H  = 240,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned V_DISP = 480
) (
    input logic                 i_clk,
    input logic                 i_rstn,
    vga_frame_scheduler_if.slave bus
);
    localparam int unsigned PIPE = RD_LAT + 2;

    typedef enum logic [1:0] {StFilling, StPending, StSwap} bank_state_e;

    bank_state_e state;
    logic        rd_bank;
    logic        wr_bank;
    logic        wr_ready;

    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] base_eff;
    logic [ADDR_W-1:0] addr_next;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    logic [PIPE-2:0] video_dly;
    logic [PIPE-2:0] hsync_dly;
    logic [PIPE-2:0] vsync_dly;
    logic [11:0]     rgb;
    logic            hsync_out;
    logic            vsync_out;

    logic at_boundary;
    logic frame_start;
    logic row_step;
    logic in_range;
    logic rd_req;

    assign at_boundary = (bus.i_y_counter == 10'(V_DISP)) && (bus.i_x_counter == 10'd0);
    assign frame_start = (bus.i_y_counter == 10'd0) && (bus.i_x_counter == 10'd0);
    // Each stored row is shown on two display lines; advance after the odd one.
    assign row_step    = (bus.i_x_counter == 10'd799) && bus.i_y_counter[0] &&
                         (bus.i_y_counter < 10'(V_DISP - 1));
    assign in_range    = (bus.i_x_counter < 10'(2 * IMG_W)) &&
                         (bus.i_y_counter < 10'(2 * IMG_H));
    assign rd_req      = bus.i_video && in_range;

    // row_base clears on the same cycle (0,0) is presented, so the first pixel
    // of a frame must not see last frame's final row_base.
    assign base_eff  = frame_start ? '0 : row_base;
    assign addr_next = base_eff + ADDR_W'(bus.i_x_counter[9:1]);

    // Bank FSM with registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= StFilling;
            rd_bank  <= 1'b0;
            wr_bank  <= 1'b1;
            wr_ready <= 1'b1;
        end else begin
            unique case (state)
                StFilling: begin
                    if (bus.i_wr_frame_done) begin
                        state    <= StPending;
                        wr_ready <= 1'b0;
                    end
                end
                StPending: begin
                    if (at_boundary) begin
                        state <= StSwap;
                    end
                end
                StSwap: begin
                    rd_bank  <= wr_bank;
                    wr_bank  <= ~wr_bank;
                    wr_ready <= 1'b1;
                    state    <= StFilling;
                end
                default: state <= StFilling;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            row_base <= '0;
        end else if (frame_start) begin
            row_base <= '0;
        end else if (row_step) begin
            row_base <= row_base + ADDR_W'(IMG_W);
        end
    end

    // Address stage; the address holds while reads are disabled.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            rd_en <= rd_req;
            if (rd_req) begin
                rd_addr <= addr_next;
            end
        end
    end

    // video/syncs travel PIPE-1 stages here, the last stage is the output register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            video_dly <= '0;
            hsync_dly <= '1;
            vsync_dly <= '1;
            rgb       <= 12'h000;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            video_dly <= {video_dly[PIPE-3:0], bus.i_video};
            hsync_dly <= {hsync_dly[PIPE-3:0], bus.i_hsync};
            vsync_dly <= {vsync_dly[PIPE-3:0], bus.i_vsync};
            rgb       <= video_dly[PIPE-2] ? bus.i_rd_data : 12'h000;
            hsync_out <= hsync_dly[PIPE-2];
            vsync_out <= vsync_dly[PIPE-2];
        end
    end

`ifdef FB_DROP_COUNT_EN
    logic [15:0] drop_count;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            drop_count <= 16'h0000;
        end else if (bus.i_wr_frame_done && (state != StFilling) &&
                     (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    assign bus.o_drop_count = drop_count;
`endif

    assign bus.o_rd_bank  = rd_bank;
    assign bus.o_wr_bank  = wr_bank;
    assign bus.o_wr_ready = wr_ready;
    assign bus.o_rd_en    = rd_en;
    assign bus.o_rd_addr  = rd_addr;
    assign bus.o_red      = rgb[11:8];
    assign bus.o_green    = rgb[7:4];
    assign bus.o_blue     = rgb[3:0];
    assign bus.o_hsync    = hsync_out;
    assign bus.o_vsync    = vsync_out;
endmodule

// File: doc/vga_frame_scheduler.md
Name: vga_frame_scheduler

Overview:
Controller between the OV7670 capture writer and the 640x480@60 VGA timing generator. It owns a two-bank BRAM frame buffer:
- swaps the display and write banks only at a frame boundary;
- generates 2x-upscaled read addresses from the VGA x/y counters;
- pipelines sync and blank signals so they align with read data.

Parameters:
IMG_W, 320, stored image width in pixels (display width / 2)
IMG_H, 240, stored image height in lines (display height / 2)
ADDR_W, 17, per-bank read address width (covers IMG_W*IMG_H)
RD_LAT, 1, BRAM read latency in cycles (1..3)
V_DISP, 480, active display lines; the swap point is line V_DISP

Ports:
i_clk  in  1  VGA pixel clock, 25 MHz
i_rstn  in  1  asynchronous active-low reset
i_x_counter  in  10  pixel column from timing generator, 0..799
i_y_counter  in  10  line from timing generator, 0..524
i_video  in  1  active-area flag from timing generator
i_hsync  in  1  active-low hsync from timing generator
i_vsync  in  1  active-low vsync from timing generator
i_wr_frame_done  in  1  one-cycle pulse: writer finished filling o_wr_bank (same clock domain)
o_wr_bank  out  1  bank the writer must fill
o_wr_ready  out  1  high: writer may begin a new frame into o_wr_bank
o_rd_bank  out  1  bank being displayed (BRAM address MSB)
o_rd_en  out  1  BRAM read enable
o_rd_addr  out  ADDR_W  address within o_rd_bank
i_rd_data  in  12  RGB444 pixel from BRAM, valid RD_LAT cycles after o_rd_en
o_red, o_green, o_blue  out  4 each  pixel to DAC
o_hsync, o_vsync  out  1 each  delayed syncs aligned to RGB

Behaviour:
Reset values:
- o_rd_bank=0, o_wr_bank=1, o_wr_ready=1, pending=0.
- o_rd_en=0, o_rd_addr=0, RGB=0, o_hsync=1, o_vsync=1.
- Entire delay pipeline cleared to blank/sync-high.
- Reset mid-operation aborts any pending swap.

Bank FSM states: FILLING, PENDING, SWAP.
- FILLING: o_wr_ready=1. i_wr_frame_done -> PENDING.
- PENDING: o_wr_ready=0; the writer must not start a frame. Leave on the first cycle with i_y_counter==V_DISP and i_x_counter==0 -> SWAP.
- SWAP (one cycle): o_rd_bank<=o_wr_bank, o_wr_bank<=~o_wr_bank -> FILLING (o_wr_ready=1 next cycle).
- i_wr_frame_done while in PENDING or SWAP is ignored (frame dropped).
- i_wr_frame_done coinciding with the boundary cycle while in FILLING enters PENDING; the swap waits one full frame.
- The banks never change between lines 0 and V_DISP-1, so there is no tearing.

Address generation:
- No multiplier. A row_base register is used, cleared when i_y_counter==0 && i_x_counter==0.
- row_base += IMG_W at i_x_counter==799 when i_y_counter is odd and below V_DISP-1.
- o_rd_addr = row_base + i_x_counter[9:1], registered (1 cycle).
- o_rd_en = registered i_video. o_rd_addr holds its last value while o_rd_en=0.
- The address never exceeds IMG_W*IMG_H-1 (76799). An out-of-range x/y input (x>=640 or y>=480 with i_video=1) forces o_rd_en=0.

Output pipeline:
- i_video, i_hsync and i_vsync are delayed PIPE = RD_LAT+2 cycles.
- Stages: 1 address register, RD_LAT for BRAM, 1 output register.
- RGB = i_rd_data split {R[11:8],G[7:4],B[3:0]} when the delayed video is 1, else 0.
- Total input-to-RGB latency is exactly PIPE cycles; the syncs have the same latency.

Optional Feature:
FB_DROP_COUNT_EN:
- Defined: adds output o_drop_count[15:0]. It increments on each ignored i_wr_frame_done, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter are absent; drops are silently ignored.

Test Plan:
1. Reset, then drive the timing generator for 2 frames without i_wr_frame_done -> o_rd_bank=0, o_wr_bank=1, o_wr_ready=1 throughout; addresses follow row_base.
2. Check addressing: at (x=0,y=0) o_rd_addr=0 one cycle later; at (x=639,y=1) o_rd_addr=319; at (x=2,y=2) o_rd_addr=321; at (x=639,y=479) o_rd_addr=76799.
3. Pulse i_wr_frame_done at y=100 -> o_wr_ready=0 next cycle. At (x=0,y=480), SWAP occurs: o_rd_bank=1 and o_wr_bank=0 one cycle later, then o_wr_ready=1.
4. Pulse i_wr_frame_done twice within one frame (y=10, y=200) -> only one swap at y=480. With FB_DROP_COUNT_EN, o_drop_count=1.
5. With RD_LAT=1 and 2, drive a BRAM model returning 12'hABC -> RGB=A/B/C exactly RD_LAT+2 cycles after i_video rises. o_hsync falls RD_LAT+2 cycles after i_hsync falls (x=656). RGB=0 during blanking.
6. Assert i_rstn=0 while in PENDING at y=300 -> all outputs return to their reset values immediately; no swap at the next y=480.
